// File: rtl/ram_byte_ctrl.sv
// Load/store sequencer: splits core byte/half/word accesses into little-endian byte RAM cycles.
// Latency: store N+1 cycles to resp_valid, load N+2, rejected request 1 (N = bytes in access).
// Backpressure: req_ready is high only in IDLE; the response is a single-cycle pulse with no stall.
module ram_byte_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        ram_r_wn,
  output logic [11:0] ram_address,
  output logic [7:0]  ram_data_in,
  input  logic [7:0]  ram_data_out
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_cnt;
  logic [31:0] r_asm;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  logic        w_accept;
  logic        w_req_err;
  logic [2:0]  w_last_idx;
  logic [2:0]  w_n;
  logic [11:0] w_byte_addr;
  logic [7:0]  w_wbyte;
  logic [31:0] w_asm_nxt;
  logic [31:0] w_ext;

  assign w_accept    = req_valid && (r_state == S_IDLE);
  assign w_byte_addr = r_addr + {10'd0, r_cnt[1:0]};
  assign w_n         = w_last_idx + 3'd1;
  assign resp_err    = r_resp_err;
  assign resp_rdata  = r_resp_rdata;

  // Reject illegal size and anything not naturally aligned before touching the RAM.
  always_comb begin
    w_req_err = 1'b0;
    case (req_size)
      2'b01:   w_req_err = req_addr[0];
      2'b10:   w_req_err = (req_addr[1:0] != 2'b00);
      2'b11:   w_req_err = 1'b1;
      default: w_req_err = 1'b0;
    endcase
  end

  // Index of the last byte of the latched access (0, 1 or 3).
  always_comb begin
    w_last_idx = 3'd0;
    case (r_size)
      2'b01:   w_last_idx = 3'd1;
      2'b10:   w_last_idx = 3'd3;
      default: w_last_idx = 3'd0;
    endcase
  end

  // Store byte for the current write cycle, least significant byte first.
  always_comb begin
    w_wbyte = r_wdata[7:0];
    case (r_cnt[1:0])
      2'd1:    w_wbyte = r_wdata[15:8];
      2'd2:    w_wbyte = r_wdata[23:16];
      2'd3:    w_wbyte = r_wdata[31:24];
      default: w_wbyte = r_wdata[7:0];
    endcase
  end

  // Read data lags its address by one cycle, so read cycle k fills byte k-1.
  always_comb begin
    w_asm_nxt = r_asm;
    case (r_cnt)
      3'd1:    w_asm_nxt[7:0]   = ram_data_out;
      3'd2:    w_asm_nxt[15:8]  = ram_data_out;
      3'd3:    w_asm_nxt[23:16] = ram_data_out;
      3'd4:    w_asm_nxt[31:24] = ram_data_out;
      default: w_asm_nxt = r_asm;
    endcase
  end

  // Sign or zero extension of the assembled load; words pass through untouched.
  always_comb begin
    w_ext = w_asm_nxt;
    case (r_size)
      2'b00:   w_ext = {{24{w_asm_nxt[7]  & ~r_unsigned}}, w_asm_nxt[7:0]};
      2'b01:   w_ext = {{16{w_asm_nxt[15] & ~r_unsigned}}, w_asm_nxt[15:0]};
      default: w_ext = w_asm_nxt;
    endcase
  end

  // State register; reset abandons any in-flight access immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and state-decoded outputs; RAM is parked in read at address 0 when idle.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    ram_r_wn    = 1'b1;
    ram_address = 12'd0;
    ram_data_in = 8'd0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_err)   w_state_nxt = S_DONE;
          else if (req_we) w_state_nxt = S_WRITE;
          else             w_state_nxt = S_READ;
        end
      end
      S_WRITE: begin
        ram_r_wn    = 1'b0;
        ram_address = w_byte_addr;
        ram_data_in = w_wbyte;
        if (r_cnt == w_last_idx) w_state_nxt = S_DONE;
      end
      S_READ: begin
        if (r_cnt <= w_last_idx) ram_address = w_byte_addr;
        if (r_cnt == w_n) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        resp_valid  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch, byte counter, load assembly and registered response fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_size       <= 2'd0;
      r_unsigned   <= 1'b0;
      r_addr       <= 12'd0;
      r_wdata      <= 32'd0;
      r_cnt        <= 3'd0;
      r_asm        <= 32'd0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= 3'd0;
          if (w_accept) begin
            r_size       <= req_size;
            r_unsigned   <= req_unsigned;
            r_addr       <= req_addr;
            r_wdata      <= req_wdata;
            r_asm        <= 32'd0;
            r_resp_err   <= w_req_err;
            r_resp_rdata <= 32'd0;
          end
        end
        S_WRITE: begin
          r_cnt <= r_cnt + 3'd1;
        end
        S_READ: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt != 3'd0)  r_asm        <= w_asm_nxt;
          if (r_cnt == w_n)   r_resp_rdata <= w_ext;
        end
        S_DONE: begin
          r_cnt        <= 3'd0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'd0;
        end
        default: r_cnt <= 3'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_byte_ctrl.sv
// Directed bench for ram_byte_ctrl with a behavioural 8x4096 registered-read RAM.
// Expected values are hand-computed constants; outputs sampled on the falling edge.
// Every wait on the DUT is bounded so the run always reaches its summary line.
module tb_ram_byte_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        ram_r_wn;
  logic [11:0] ram_address;
  logic [7:0]  ram_data_in;
  logic [7:0]  ram_data_out;

  logic [7:0]  mem [0:4095];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_byte_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .ram_r_wn     (ram_r_wn),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  // Byte RAM: synchronous write, registered read.
  always @(posedge clk) begin
    if (!ram_r_wn) mem[ram_address] <= ram_data_in;
    ram_data_out <= mem[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One handshake; cyc is the cycle after acceptance in which resp_valid appears (-1 if never).
  task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                     input logic [11:0] addr, input logic [31:0] wd,
                     output int cyc, output logic err, output logic [31:0] rd, output int nwr);
    int w;
    cyc = -1; err = 1'b0; rd = 32'd0; nwr = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      chk("ready_wait", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // Scramble inputs after acceptance; the DUT must use its latched copy.
    req_valid = 1'b0; req_we = ~we; req_size = 2'b00; req_unsigned = ~uns;
    req_addr = ~addr; req_wdata = ~wd;
    for (int c = 1; c <= 20; c++) begin
      if (!ram_r_wn) nwr++;
      if (resp_valid) begin
        cyc = c; err = resp_err; rd = resp_rdata;
        break;
      end
      @(negedge clk);
    end
  endtask

  int          cyc, nwr, c, bad, pulses;
  logic        err;
  logic [31:0] rd;
  logic [7:0]  m0, m3, m4, m100;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 12'd0; req_wdata = 32'd0;

    // Reset asserted mid-cycle must take effect immediately.
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_ready",   32'(req_ready),   32'd1);
    chk("rst_rvalid",  32'(resp_valid),  32'd0);
    chk("rst_rerr",    32'(resp_err),    32'd0);
    chk("rst_rdata",   resp_rdata,       32'd0);
    chk("rst_r_wn",    32'(ram_r_wn),    32'd1);
    chk("rst_addr",    32'(ram_address), 32'd0);
    chk("rst_din",     32'(ram_data_in), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!req_ready || !ram_r_wn || resp_valid) bad++;
    end
    chk("idle10_bad", 32'(bad), 32'd0);

    // Word store then load at 0x100.
    txn(1'b1, 2'b10, 1'b0, 12'h100, 32'hDEADBEEF, cyc, err, rd, nwr);
    chk("wst_cyc",   32'(cyc), 32'd5);
    chk("wst_err",   32'(err), 32'd0);
    chk("wst_rdata", rd,       32'd0);
    chk("wst_nwr",   32'(nwr), 32'd4);
    chk("wst_mem",   {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]}, 32'hDEADBEEF);
    txn(1'b0, 2'b10, 1'b1, 12'h100, 32'h0, cyc, err, rd, nwr);
    chk("wld_cyc",   32'(cyc), 32'd6);
    chk("wld_err",   32'(err), 32'd0);
    chk("wld_rdata", rd,       32'hDEADBEEF);
    chk("wld_nwr",   32'(nwr), 32'd0);

    // Extension: byte 0x80 at 0x010, half 0x8001 at 0x012; upper wdata bits are junk.
    txn(1'b1, 2'b00, 1'b0, 12'h010, 32'h12345680, cyc, err, rd, nwr);
    chk("bst_cyc",  32'(cyc), 32'd2);
    chk("bst_nwr",  32'(nwr), 32'd1);
    txn(1'b1, 2'b01, 1'b0, 12'h012, 32'hABCD8001, cyc, err, rd, nwr);
    chk("hst_cyc",  32'(cyc), 32'd3);
    chk("hst_mem",  {16'd0, mem[12'h013], mem[12'h012]}, 32'h00008001);
    txn(1'b0, 2'b00, 1'b0, 12'h010, 32'h0, cyc, err, rd, nwr);
    chk("lb_cyc",   32'(cyc), 32'd3);
    chk("lb_s",     rd,       32'hFFFFFF80);
    txn(1'b0, 2'b00, 1'b1, 12'h010, 32'h0, cyc, err, rd, nwr);
    chk("lb_u",     rd,       32'h00000080);
    txn(1'b0, 2'b01, 1'b0, 12'h012, 32'h0, cyc, err, rd, nwr);
    chk("lh_cyc",   32'(cyc), 32'd4);
    chk("lh_s",     rd,       32'hFFFF8001);
    txn(1'b0, 2'b01, 1'b1, 12'h012, 32'h0, cyc, err, rd, nwr);
    chk("lh_u",     rd,       32'h00008001);

    // Misaligned / illegal requests are rejected without a RAM write.
    txn(1'b1, 2'b00, 1'b0, 12'h003, 32'h0000005A, cyc, err, rd, nwr);
    txn(1'b1, 2'b00, 1'b0, 12'h004, 32'h000000A5, cyc, err, rd, nwr);
    txn(1'b1, 2'b00, 1'b0, 12'h000, 32'h0000003C, cyc, err, rd, nwr);
    m0 = mem[0]; m3 = mem[3]; m4 = mem[4]; m100 = mem[12'h100];
    chk("pre_m3",    32'(m3), 32'h5A);
    txn(1'b0, 2'b10, 1'b0, 12'h101, 32'h0, cyc, err, rd, nwr);
    chk("mw_cyc",    32'(cyc), 32'd1);
    chk("mw_err",    32'(err), 32'd1);
    chk("mw_rdata",  rd,       32'd0);
    chk("mw_nwr",    32'(nwr), 32'd0);
    txn(1'b1, 2'b01, 1'b0, 12'h003, 32'hFFFFFFFF, cyc, err, rd, nwr);
    chk("mh_cyc",    32'(cyc), 32'd1);
    chk("mh_err",    32'(err), 32'd1);
    chk("mh_nwr",    32'(nwr), 32'd0);
    txn(1'b1, 2'b11, 1'b0, 12'h000, 32'hFFFFFFFF, cyc, err, rd, nwr);
    chk("sz3_cyc",   32'(cyc), 32'd1);
    chk("sz3_err",   32'(err), 32'd1);
    chk("sz3_rdata", rd,       32'd0);
    chk("sz3_nwr",   32'(nwr), 32'd0);
    chk("err_mem",   {mem[0], mem[3], mem[4], mem[12'h100]}, {m0, m3, m4, m100});

    // Top boundary with back-to-back handshake: store then load at 0xFFC.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 12'hFFC; req_wdata = 32'h01020304;
    @(negedge clk);
    req_we = 1'b0; req_wdata = 32'h0;
    c = 1;
    while (!req_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("tp_ready_cyc", 32'(c), 32'd6);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = -1; rd = 32'd0;
    for (int k = 1; k <= 20; k++) begin
      if (resp_valid) begin
        cyc = k; rd = resp_rdata;
        break;
      end
      @(negedge clk);
    end
    chk("tp_ld_cyc",   32'(cyc), 32'd6);
    chk("tp_ld_rdata", rd,       32'h01020304);
    chk("tp_mem_ffc",  {mem[12'hFFF], mem[12'hFFE], mem[12'hFFD], mem[12'hFFC]}, 32'h01020304);
    chk("tp_mem0",     32'(mem[0]), 32'(m0));

    // Reset after two of four store bytes have been written.
    txn(1'b1, 2'b10, 1'b0, 12'h200, 32'h44332211, cyc, err, rd, nwr);
    chk("pre_cyc", 32'(cyc), 32'd5);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 12'h200;
    req_wdata = 32'hAABBCCDD;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_r_wn",  32'(ram_r_wn),  32'd1);
    chk("mrst_ready", 32'(req_ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid || !ram_r_wn) pulses++;
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid || !ram_r_wn) pulses++;
    end
    chk("mrst_pulses", 32'(pulses), 32'd0);
    chk("mrst_mem", {mem[12'h203], mem[12'h202], mem[12'h201], mem[12'h200]}, 32'h4433CCDD);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
